// File: rtl/delay_sum_combiner_if.sv
// Bus bundle for delay_sum_combiner: frame input, delay configuration,
// and the combined-sample output with its status flags.
interface delay_sum_combiner_if #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 8,
    parameter int DELAY_W = 4
);
    logic                      sample_valid;
    logic [NUM_CH*DATA_W-1:0]  sample_in;
    logic                      cfg_load;
    logic [NUM_CH*DELAY_W-1:0] cfg_delay;
    logic                      busy;
    logic                      out_valid;
    logic [DATA_W-1:0]         sum_out;
    logic                      overrun;

    modport master (
        output sample_valid, sample_in, cfg_load, cfg_delay,
        input  busy, out_valid, sum_out, overrun
    );

    modport slave (
        input  sample_valid, sample_in, cfg_load, cfg_delay,
        output busy, out_valid, sum_out, overrun
    );
endinterface

// File: rtl/delay_sum_combiner.sv
// Delay-and-sum beamformer core. Each accepted PCM frame is written into a
// per-channel circular history; channels are then read back at their own
// programmed delay and accumulated one channel per clock into sum_out.
// Optional feature macro: DELAY_SUM_AVERAGE_EN -- when defined, sum_out is the
// channel average (arithmetic right shift of the full sum) instead of the
// saturated full sum.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for sample_valid; cfg_load latches channel delays
// ACCUM | adding one delayed channel per clock; last channel emits sum_out
module delay_sum_combiner #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int DELAY_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    delay_sum_combiner_if.slave   bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int ACC_W = DATA_W + CH_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [DATA_W-1:0]         hist [NUM_CH][DEPTH];
    logic [DELAY_W-1:0]        delay [NUM_CH];
    logic [DELAY_W-1:0]        wr_ptr;
    logic [DELAY_W-1:0]        cur;
    logic [CH_W-1:0]           ch;
    logic signed [ACC_W-1:0]   acc;
    logic                      out_valid;
    logic [DATA_W-1:0]         sum_out;
    logic                      overrun;

    logic                      accept;
    logic                      last;
    logic [DELAY_W-1:0]        rd_idx;
    logic [DATA_W-1:0]         rd_sample;
    logic signed [ACC_W-1:0]   addend;
    logic signed [ACC_W-1:0]   acc_next;
    logic [DATA_W-1:0]         result;

    // Delay subtraction wraps naturally in DELAY_W bits, giving the circular read.
    assign rd_idx    = cur - delay[ch];
    assign rd_sample = hist[ch][rd_idx];
    assign addend    = {{CH_W{rd_sample[DATA_W-1]}}, rd_sample};
    assign acc_next  = acc + addend;

    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid;
    assign bus.sum_out   = sum_out;
    assign bus.overrun   = overrun;

    // Next-state decode: accept a frame in IDLE, leave ACCUM after the last channel.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sample_valid) begin
                    accept    = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (ch == CH_W'(NUM_CH - 1)) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output formatting of the completed sum: averaged or saturated.
    always_comb begin
`ifdef DELAY_SUM_AVERAGE_EN
        result = DATA_W'(acc_next >>> CH_W);
`else
        if (acc_next > SAT_MAX) begin
            result = DATA_W'(SAT_MAX);
        end else if (acc_next < SAT_MIN) begin
            result = DATA_W'(SAT_MIN);
        end else begin
            result = DATA_W'(acc_next);
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: history writes, delay latch, accumulation, output and overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                delay[c] <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    hist[c][e] <= '0;
                end
            end
            wr_ptr    <= '0;
            cur       <= '0;
            ch        <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            sum_out   <= '0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                // Delays land before ACCUM starts, so a same-cycle load applies to this frame.
                if (bus.cfg_load) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        delay[c] <= bus.cfg_delay[c*DELAY_W +: DELAY_W];
                    end
                end
                if (accept) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        hist[c][wr_ptr] <= bus.sample_in[c*DATA_W +: DATA_W];
                    end
                    cur    <= wr_ptr;
                    wr_ptr <= wr_ptr + DELAY_W'(1);
                    acc    <= '0;
                    ch     <= '0;
                end
            end else begin
                acc <= acc_next;
                ch  <= ch + CH_W'(1);
                if (bus.sample_valid) begin
                    overrun <= 1'b1;
                end
                if (last) begin
                    sum_out   <= result;
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_delay_sum_combiner.sv
// Bench for delay_sum_combiner: directed scenarios followed by random traffic,
// checked against a frame-history model with a scoreboard queue.
module tb_delay_sum_combiner;
    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int DELAY_W = 4;
    localparam int CH_W    = $clog2(NUM_CH);

    logic clk;
    logic reset;

    delay_sum_combiner_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DELAY_W(DELAY_W)) bus ();

    delay_sum_combiner #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DELAY_W(DELAY_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [NUM_CH*DATA_W-1:0] frames[$];
    int m_dly [NUM_CH];
    int busy_left = 0;
    int m_ovr = 0;
    int exp_val[$];
    int exp_cyc[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int expected_sum();
        int s = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            int idx = frames.size() - 1 - m_dly[c];
            if (idx >= 0) begin
                logic signed [DATA_W-1:0] v;
                v = frames[idx][c*DATA_W +: DATA_W];
                s += int'(v);
            end
        end
`ifdef DELAY_SUM_AVERAGE_EN
        s = s >>> CH_W;
`else
        if (s > (2 ** (DATA_W - 1)) - 1) s = (2 ** (DATA_W - 1)) - 1;
        if (s < -(2 ** (DATA_W - 1))) s = -(2 ** (DATA_W - 1));
`endif
        return s;
    endfunction

    task automatic model_step(input bit rst, input bit sv, input logic [NUM_CH*DATA_W-1:0] data,
                              input bit cl, input logic [NUM_CH*DELAY_W-1:0] dl);
        if (rst) begin
            frames.delete();
            exp_val.delete();
            exp_cyc.delete();
            for (int c = 0; c < NUM_CH; c++) m_dly[c] = 0;
            busy_left = 0;
            m_ovr = 0;
        end else if (busy_left == 0) begin
            if (cl) begin
                for (int c = 0; c < NUM_CH; c++) m_dly[c] = int'(dl[c*DELAY_W +: DELAY_W]);
            end
            if (sv) begin
                frames.push_back(data);
                exp_val.push_back(expected_sum());
                exp_cyc.push_back(cyc + NUM_CH + 1);
                busy_left = NUM_CH;
            end
        end else begin
            busy_left--;
            if (sv) m_ovr = 1;
        end
    endtask

    task automatic drive(input bit rst, input bit sv, input logic [NUM_CH*DATA_W-1:0] data,
                         input bit cl, input logic [NUM_CH*DELAY_W-1:0] dl);
        reset            = rst;
        bus.sample_valid = sv;
        bus.sample_in    = data;
        bus.cfg_load     = cl;
        bus.cfg_delay    = dl;
        @(posedge clk);
        model_step(rst, sv, data, cl, dl);
        cyc++;
        #1;
        check("busy", int'(bus.busy), int'(busy_left != 0));
        check("overrun", int'(bus.overrun), m_ovr);
        if (rst) begin
            check("sum_out_after_reset", int'(bus.sum_out), 0);
            check("out_valid_after_reset", int'(bus.out_valid), 0);
        end
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] pack2(input int l, input int r);
        logic [DATA_W-1:0] lv;
        logic [DATA_W-1:0] rv;
        lv = DATA_W'(l);
        rv = DATA_W'(r);
        return {rv, lv};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic frame(input int l, input int r);
        drive(1'b0, 1'b1, pack2(l, r), 1'b0, '0);
        idle(NUM_CH);
    endtask

    task automatic set_delays(input int d0, input int d1);
        logic [DELAY_W-1:0] a;
        logic [DELAY_W-1:0] b;
        a = DELAY_W'(d0);
        b = DELAY_W'(d1);
        drive(1'b0, 1'b0, '0, 1'b1, {b, a});
    endtask

    // Scoreboard monitor: every out_valid pops one expected result and its due cycle.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (exp_val.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                logic signed [DATA_W-1:0] act;
                int ev;
                int ec;
                act = bus.sum_out;
                ev = exp_val.pop_front();
                ec = exp_cyc.pop_front();
                check("sum_out", int'(act), ev);
                check("out_cycle", cyc, ec);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_in = '0;
        bus.cfg_load = 1'b0;
        bus.cfg_delay = '0;

        // basic sum, reset state
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        set_delays(0, 0);
        frame(10, 20);
        idle(2);

        // saturation / averaging extremes
        frame(100, 100);
        frame(-100, -100);
        frame(127, 127);
        frame(-128, -128);
        idle(2);

        // per-channel delays
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        set_delays(0, 2);
        frame(1, 10);
        frame(2, 20);
        frame(3, 30);
        idle(2);

        // overrun: back-to-back strobes
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        drive(1'b0, 1'b1, pack2(5, 6), 1'b0, '0);
        drive(1'b0, 1'b1, pack2(7, 8), 1'b0, '0);
        idle(4);
        drive(1'b0, 1'b0, '0, 1'b1, '1);
        frame(9, 9);
        idle(2);

        // wrap-around with maximum delay
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        set_delays(0, 15);
        for (int n = 1; n <= 20; n++) frame(0, n);
        idle(2);

        // reset during ACCUM, then history must read as zero
        set_delays(0, 1);
        frame(11, 22);
        drive(1'b0, 1'b1, pack2(33, 44), 1'b0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        idle(2);
        set_delays(1, 1);
        frame(50, 60);
        idle(2);

        // same-cycle cfg_load and sample_valid
        drive(1'b0, 1'b1, pack2(-7, 3), 1'b1, {4'd0, 4'd1});
        idle(NUM_CH + 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            bit sv;
            bit cl;
            rst = ($urandom_range(0, 199) == 0);
            sv  = ($urandom_range(0, 99) < 45);
            cl  = ($urandom_range(0, 99) < 8);
            drive(rst, sv, NUM_CH*DATA_W'($urandom), cl, NUM_CH*DELAY_W'($urandom));
        end
        idle(NUM_CH + 3);

        check("scoreboard_drained", exp_val.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
